// File: rtl/ddr_read_control.sv
// DDR line reader: fetches one display line per request from DDR and writes it
// into a double-buffered line RAM, tracking frame/row across vertical syncs.
module ddr_read_control #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 27
) (
    input  logic                  i_sclk,
    input  logic                  i_rst_n,
    input  logic                  i_soft_rst,
    input  logic [3:0]            i_sub_space_num,
    input  logic [11:0]           i_rd_numb,
    input  logic                  i_syn_v,
    input  logic [1:0]            i_wr_frame_numb,
    input  logic                  i_line_req,
    input  logic                  i_ddr_rd_prio_ini_vld,
    input  logic [15:0]           i_ddr_rd_prio_ini,
    output logic [15:0]           o_ddr_rd_priority,
    output logic                  o_ddr_rd_req,
    input  logic                  i_ddr_rd_ack,
    output logic [ADDR_WIDTH-1:0] o_ddr_rd_start_addr,
    output logic [11:0]           o_ddr_rd_data_length,
    input  logic                  i_ddr_rd_data_vld,
    input  logic [DATA_WIDTH-1:0] i_ddr_rd_data,
    input  logic                  i_ddr_rd_done,
    output logic                  o_ram_wr_en,
    output logic [7:0]            o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic                  o_line_rdy,
    output logic                  o_line_half,
    output logic [1:0]            o_frame_numb,
    output logic                  o_ddr_req_lose
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

    state_t      state;
    logic        syn_meta;
    logic        syn_sync;
    logic        syn_prev;
    logic        vs_rise;
    logic        vs_pend;
    logic [1:0]  pend_frame;
    logic [1:0]  vs_frame;
    logic [10:0] row;
    logic        half;
    logic [7:0]  beat_cnt;
    logic [15:0] prio_ini_q;
    logic        req_accept;
    logic        beat_ok;
    logic [11:0] rd_len;
    logic [26:0] addr_fields;

    assign vs_rise    = syn_sync & ~syn_prev;
    // Two-bit subtraction gives the "frame 0 -> 3" wrap for free.
    assign vs_frame   = i_wr_frame_numb - 2'd1;
    assign rd_len     = (i_rd_numb > 12'd128) ? 12'd128 : i_rd_numb;
    assign req_accept = (state == IDLE) && i_line_req && (i_rd_numb != 12'd0);
    assign beat_ok    = i_ddr_rd_data_vld && ({4'd0, beat_cnt} < o_ddr_rd_data_length);

    // A vsync arriving in the same cycle as a request already addresses the new frame.
    assign addr_fields = {i_sub_space_num,
                          vs_rise ? vs_frame : o_frame_numb,
                          vs_rise ? 11'd0 : row,
                          10'd0};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; soft reset is a synchronous mirror of rst_n.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= IDLE;
            syn_meta             <= 1'b0;
            syn_sync             <= 1'b0;
            syn_prev             <= 1'b0;
            vs_pend              <= 1'b0;
            pend_frame           <= 2'd0;
            row                  <= 11'd0;
            half                 <= 1'b0;
            beat_cnt             <= 8'd0;
            o_ddr_rd_req         <= 1'b0;
            o_ddr_rd_start_addr  <= '0;
            o_ddr_rd_data_length <= 12'd0;
            o_ram_wr_en          <= 1'b0;
            o_ram_wr_addr        <= 8'd0;
            o_ram_wr_data        <= '0;
            o_line_rdy           <= 1'b0;
            o_line_half          <= 1'b0;
            o_frame_numb         <= 2'd0;
            o_ddr_req_lose       <= 1'b0;
        end else if (i_soft_rst) begin
            state                <= IDLE;
            syn_meta             <= 1'b0;
            syn_sync             <= 1'b0;
            syn_prev             <= 1'b0;
            vs_pend              <= 1'b0;
            pend_frame           <= 2'd0;
            row                  <= 11'd0;
            half                 <= 1'b0;
            beat_cnt             <= 8'd0;
            o_ddr_rd_req         <= 1'b0;
            o_ddr_rd_start_addr  <= '0;
            o_ddr_rd_data_length <= 12'd0;
            o_ram_wr_en          <= 1'b0;
            o_ram_wr_addr        <= 8'd0;
            o_ram_wr_data        <= '0;
            o_line_rdy           <= 1'b0;
            o_line_half          <= 1'b0;
            o_frame_numb         <= 2'd0;
            o_ddr_req_lose       <= 1'b0;
        end else begin
            syn_meta       <= i_syn_v;
            syn_sync       <= syn_meta;
            syn_prev       <= syn_sync;
            o_ram_wr_en    <= 1'b0;
            o_line_rdy     <= 1'b0;
            o_ddr_req_lose <= i_line_req && (state != IDLE);

            // A vsync during a burst is parked until the line finishes.
            if (vs_rise && (state == REQ || state == WAIT_DATA)) begin
                vs_pend    <= 1'b1;
                pend_frame <= vs_frame;
            end

            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        row          <= 11'd0;
                        half         <= 1'b0;
                        o_frame_numb <= vs_frame;
                    end
                    if (req_accept) begin
                        state                <= REQ;
                        o_ddr_rd_req         <= 1'b1;
                        o_ddr_rd_start_addr  <= ADDR_WIDTH'(addr_fields);
                        o_ddr_rd_data_length <= rd_len;
                        beat_cnt             <= 8'd0;
                    end
                end
                REQ: begin
                    if (i_ddr_rd_ack) begin
                        o_ddr_rd_req <= 1'b0;
                        state        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (beat_ok) begin
                        o_ram_wr_en   <= 1'b1;
                        o_ram_wr_addr <= {half, beat_cnt[6:0]};
                        o_ram_wr_data <= i_ddr_rd_data;
                        beat_cnt      <= beat_cnt + 8'd1;
                    end
                    if (i_ddr_rd_done) begin
                        state       <= DONE;
                        o_line_rdy  <= 1'b1;
                        o_line_half <= half;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (vs_pend || vs_rise) begin
                        row          <= 11'd0;
                        half         <= 1'b0;
                        o_frame_numb <= vs_rise ? vs_frame : pend_frame;
                        vs_pend      <= 1'b0;
                    end else begin
                        row  <= row + 11'd1;
                        half <= ~half;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arbitration priority ages while a request waits; a fresh load always wins.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ddr_rd_priority <= 16'd0;
            prio_ini_q        <= 16'd0;
        end else if (i_soft_rst) begin
            o_ddr_rd_priority <= 16'd0;
            prio_ini_q        <= 16'd0;
        end else if (i_ddr_rd_prio_ini_vld) begin
            o_ddr_rd_priority <= i_ddr_rd_prio_ini;
            prio_ini_q        <= i_ddr_rd_prio_ini;
        end else if (state == REQ) begin
            if (i_ddr_rd_ack)
                o_ddr_rd_priority <= prio_ini_q;
            else if (o_ddr_rd_priority != 16'hFFFF)
                o_ddr_rd_priority <= o_ddr_rd_priority + 16'd1;
        end
    end

endmodule

// File: tb/tb_ddr_read_control.sv
// Directed bench for ddr_read_control: line fetch, RAM writes, vsync handling,
// length clamping, priority aging, request loss and soft reset.
module tb_ddr_read_control;

    localparam int DW = 128;
    localparam int AW = 27;

    logic          i_sclk = 1'b0;
    logic          i_rst_n;
    logic          i_soft_rst;
    logic [3:0]    i_sub_space_num;
    logic [11:0]   i_rd_numb;
    logic          i_syn_v;
    logic [1:0]    i_wr_frame_numb;
    logic          i_line_req;
    logic          i_ddr_rd_prio_ini_vld;
    logic [15:0]   i_ddr_rd_prio_ini;
    logic [15:0]   o_ddr_rd_priority;
    logic          o_ddr_rd_req;
    logic          i_ddr_rd_ack;
    logic [AW-1:0] o_ddr_rd_start_addr;
    logic [11:0]   o_ddr_rd_data_length;
    logic          i_ddr_rd_data_vld;
    logic [DW-1:0] i_ddr_rd_data;
    logic          i_ddr_rd_done;
    logic          o_ram_wr_en;
    logic [7:0]    o_ram_wr_addr;
    logic [DW-1:0] o_ram_wr_data;
    logic          o_line_rdy;
    logic          o_line_half;
    logic [1:0]    o_frame_numb;
    logic          o_ddr_req_lose;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_read_control #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_sclk                (i_sclk),
        .i_rst_n               (i_rst_n),
        .i_soft_rst            (i_soft_rst),
        .i_sub_space_num       (i_sub_space_num),
        .i_rd_numb             (i_rd_numb),
        .i_syn_v               (i_syn_v),
        .i_wr_frame_numb       (i_wr_frame_numb),
        .i_line_req            (i_line_req),
        .i_ddr_rd_prio_ini_vld (i_ddr_rd_prio_ini_vld),
        .i_ddr_rd_prio_ini     (i_ddr_rd_prio_ini),
        .o_ddr_rd_priority     (o_ddr_rd_priority),
        .o_ddr_rd_req          (o_ddr_rd_req),
        .i_ddr_rd_ack          (i_ddr_rd_ack),
        .o_ddr_rd_start_addr   (o_ddr_rd_start_addr),
        .o_ddr_rd_data_length  (o_ddr_rd_data_length),
        .i_ddr_rd_data_vld     (i_ddr_rd_data_vld),
        .i_ddr_rd_data         (i_ddr_rd_data),
        .i_ddr_rd_done         (i_ddr_rd_done),
        .o_ram_wr_en           (o_ram_wr_en),
        .o_ram_wr_addr         (o_ram_wr_addr),
        .o_ram_wr_data         (o_ram_wr_data),
        .o_line_rdy            (o_line_rdy),
        .o_line_half           (o_line_half),
        .o_frame_numb          (o_frame_numb),
        .o_ddr_req_lose        (o_ddr_req_lose)
    );

    always #5 i_sclk = ~i_sclk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    function automatic logic [DW-1:0] beat_data(input int i);
        beat_data = {4{32'hA500_0000 + 32'(i)}};
    endfunction

    task automatic vs_pulse(input logic [1:0] wr_frame);
        i_wr_frame_numb = wr_frame;
        i_syn_v = 1'b1;
        repeat (4) tick();
        i_syn_v = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_line(input logic [11:0] rd, input logic [AW-1:0] exp_addr,
                              input logic [11:0] exp_len);
        i_rd_numb  = rd;
        i_line_req = 1'b1;
        tick();
        i_line_req = 1'b0;
        n_checks++;
        if (o_ddr_rd_req !== 1'b1) begin
            n_fail++; $display("FAIL req_assert: got %0b want 1", o_ddr_rd_req);
        end
        n_checks++;
        if (o_ddr_rd_start_addr !== exp_addr) begin
            n_fail++; $display("FAIL start_addr: got %h want %h", o_ddr_rd_start_addr, exp_addr);
        end
        n_checks++;
        if (o_ddr_rd_data_length !== exp_len) begin
            n_fail++; $display("FAIL length: got %0d want %0d", o_ddr_rd_data_length, exp_len);
        end
        i_ddr_rd_ack = 1'b1;
        tick();
        i_ddr_rd_ack = 1'b0;
        n_checks++;
        if (o_ddr_rd_req !== 1'b0) begin
            n_fail++; $display("FAIL req_after_ack: got %0b want 0", o_ddr_rd_req);
        end
    endtask

    // n beats; the done pulse rides on the last beat, or on an extra beat
    // past the latched length when extra is set.
    task automatic run_line(input int n, input logic [7:0] base, input logic exp_half,
                            input logic extra);
        for (int i = 0; i < n; i++) begin
            i_ddr_rd_data_vld = 1'b1;
            i_ddr_rd_data     = beat_data(i);
            i_ddr_rd_done     = (i == n - 1) && !extra;
            tick();
            n_checks++;
            if ({o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data} !== {1'b1, base + 8'(i), beat_data(i)}) begin
                n_fail++;
                $display("FAIL ram_write beat %0d: got en=%0b addr=%h want en=1 addr=%h",
                         i, o_ram_wr_en, o_ram_wr_addr, base + 8'(i));
            end
        end
        if (extra) begin
            i_ddr_rd_data_vld = 1'b1;
            i_ddr_rd_data     = beat_data(n);
            i_ddr_rd_done     = 1'b1;
            tick();
            n_checks++;
            if (o_ram_wr_en !== 1'b0) begin
                n_fail++; $display("FAIL overrun_beat_written: got en=%0b want 0", o_ram_wr_en);
            end
        end
        i_ddr_rd_data_vld = 1'b0;
        i_ddr_rd_done     = 1'b0;
        n_checks++;
        if ({o_line_rdy, o_line_half} !== {1'b1, exp_half}) begin
            n_fail++;
            $display("FAIL line_rdy: got rdy=%0b half=%0b want rdy=1 half=%0b",
                     o_line_rdy, o_line_half, exp_half);
        end
        tick();
        n_checks++;
        if (o_line_rdy !== 1'b0) begin
            n_fail++; $display("FAIL line_rdy_pulse: got %0b want 0", o_line_rdy);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({o_ddr_rd_req, o_ram_wr_en, o_line_rdy, o_ddr_req_lose, o_frame_numb} !== 6'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {o_ddr_rd_req, o_ram_wr_en, o_line_rdy, o_ddr_req_lose, o_frame_numb});
        end
        n_checks++;
        if ({o_ddr_rd_start_addr, o_ddr_rd_data_length, o_ddr_rd_priority} !== '0) begin
            n_fail++; $display("FAIL reset_regs: got addr=%h len=%0d prio=%h want 0",
                o_ddr_rd_start_addr, o_ddr_rd_data_length, o_ddr_rd_priority);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_lines();
        i_sub_space_num = 4'h5;
        vs_pulse(2'd2);
        n_checks++;
        if (o_frame_numb !== 2'd1) begin
            n_fail++; $display("FAIL frame_after_vs: got %0d want 1", o_frame_numb);
        end
        start_line(12'd64, 27'h2A0_0000, 12'd64);
        run_line(64, 8'h00, 1'b0, 1'b0);
        start_line(12'd64, 27'h2A0_0400, 12'd64);
        run_line(64, 8'h80, 1'b1, 1'b1);
    endtask

    task automatic test_vs_pending();
        start_line(12'd4, 27'h2A0_0800, 12'd4);
        vs_pulse(2'd3);
        n_checks++;
        if (o_frame_numb !== 2'd1) begin
            n_fail++; $display("FAIL frame_mid_burst: got %0d want 1", o_frame_numb);
        end
        run_line(4, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (o_frame_numb !== 2'd2) begin
            n_fail++; $display("FAIL frame_after_pending_vs: got %0d want 2", o_frame_numb);
        end
        start_line(12'd2, 27'h2C0_0000, 12'd2);
        run_line(2, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_frame_clamp();
        vs_pulse(2'd0);
        n_checks++;
        if (o_frame_numb !== 2'd3) begin
            n_fail++; $display("FAIL frame_wrap: got %0d want 3", o_frame_numb);
        end
        i_rd_numb  = 12'd0;
        i_line_req = 1'b1;
        tick();
        i_line_req = 1'b0;
        tick();
        n_checks++;
        if ({o_ddr_rd_req, o_ddr_req_lose} !== 2'b00) begin
            n_fail++; $display("FAIL zero_len_ignored: got req=%0b lose=%0b want 0 0",
                o_ddr_rd_req, o_ddr_req_lose);
        end
        start_line(12'd200, 27'h2E0_0000, 12'd128);
        run_line(1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        i_ddr_rd_prio_ini_vld = 1'b1;
        i_ddr_rd_prio_ini     = 16'h0010;
        tick();
        i_ddr_rd_prio_ini_vld = 1'b0;
        n_checks++;
        if (o_ddr_rd_priority !== 16'h0010) begin
            n_fail++; $display("FAIL prio_load: got %h want 0010", o_ddr_rd_priority);
        end
        i_rd_numb  = 12'd4;
        i_line_req = 1'b1;
        tick();
        i_line_req = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (o_ddr_rd_priority !== 16'h0015) begin
            n_fail++; $display("FAIL prio_aged: got %h want 0015", o_ddr_rd_priority);
        end
        i_ddr_rd_ack = 1'b1;
        tick();
        i_ddr_rd_ack = 1'b0;
        n_checks++;
        if (o_ddr_rd_priority !== 16'h0010) begin
            n_fail++; $display("FAIL prio_reload: got %h want 0010", o_ddr_rd_priority);
        end
        i_ddr_rd_done = 1'b1;
        tick();
        i_ddr_rd_done = 1'b0;
        tick();
        i_ddr_rd_prio_ini_vld = 1'b1;
        i_ddr_rd_prio_ini     = 16'hFFFE;
        i_line_req            = 1'b1;
        tick();
        i_ddr_rd_prio_ini_vld = 1'b0;
        i_line_req            = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (o_ddr_rd_priority !== 16'hFFFF) begin
            n_fail++; $display("FAIL prio_saturate: got %h want ffff", o_ddr_rd_priority);
        end
        i_ddr_rd_ack = 1'b1;
        tick();
        i_ddr_rd_ack  = 1'b0;
        i_ddr_rd_done = 1'b1;
        tick();
        i_ddr_rd_done = 1'b0;
        tick();
        n_checks++;
        if (o_ddr_rd_priority !== 16'hFFFE) begin
            n_fail++; $display("FAIL prio_reload_sat: got %h want fffe", o_ddr_rd_priority);
        end
    endtask

    task automatic test_lose_soft_rst();
        start_line(12'd8, 27'h2E0_0C00, 12'd8);
        i_line_req = 1'b1;
        tick();
        i_line_req = 1'b0;
        n_checks++;
        if (o_ddr_req_lose !== 1'b1) begin
            n_fail++; $display("FAIL lose_pulse: got %0b want 1", o_ddr_req_lose);
        end
        tick();
        n_checks++;
        if ({o_ddr_req_lose, o_ddr_rd_req} !== 2'b00) begin
            n_fail++; $display("FAIL lose_single: got lose=%0b req=%0b want 0 0",
                o_ddr_req_lose, o_ddr_rd_req);
        end
        i_ddr_rd_data_vld = 1'b1;
        i_ddr_rd_data     = beat_data(0);
        tick();
        i_ddr_rd_data_vld = 1'b0;
        n_checks++;
        if ({o_ram_wr_en, o_ram_wr_addr} !== {1'b1, 8'h80}) begin
            n_fail++; $display("FAIL partial_beat: got en=%0b addr=%h want en=1 addr=80",
                o_ram_wr_en, o_ram_wr_addr);
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        n_checks++;
        if ({o_ddr_rd_req, o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_line_rdy, o_ddr_req_lose,
             o_frame_numb, o_ddr_rd_start_addr, o_ddr_rd_data_length, o_ddr_rd_priority} !== '0) begin
            n_fail++; $display("FAIL soft_rst_outputs: got addr=%h len=%0d prio=%h frame=%0d want all 0",
                o_ddr_rd_start_addr, o_ddr_rd_data_length, o_ddr_rd_priority, o_frame_numb);
        end
        i_ddr_rd_data_vld = 1'b1;
        i_ddr_rd_done     = 1'b1;
        tick();
        i_ddr_rd_data_vld = 1'b0;
        i_ddr_rd_done     = 1'b0;
        n_checks++;
        if ({o_ram_wr_en, o_line_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL abandoned_beats: got en=%0b rdy=%0b want 0 0",
                o_ram_wr_en, o_line_rdy);
        end
        start_line(12'd1, 27'h280_0000, 12'd1);
        run_line(1, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst_n               = 1'b0;
        i_soft_rst            = 1'b0;
        i_sub_space_num       = 4'h0;
        i_rd_numb             = 12'd0;
        i_syn_v               = 1'b0;
        i_wr_frame_numb       = 2'd0;
        i_line_req            = 1'b0;
        i_ddr_rd_prio_ini_vld = 1'b0;
        i_ddr_rd_prio_ini     = 16'd0;
        i_ddr_rd_ack          = 1'b0;
        i_ddr_rd_data_vld     = 1'b0;
        i_ddr_rd_data         = '0;
        i_ddr_rd_done         = 1'b0;

        test_reset();
        test_first_lines();
        test_vs_pending();
        test_frame_clamp();
        test_priority();
        test_lose_soft_rst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_read_control.md
DDR_READ_CONTROL -- requirements
Module: ddr_read_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, DDR read data / line-RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 27, DDR address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: i_sclk  in  1  DDR user clock; i_rst_n  in  1  async active-low reset.
REQ-004 i_soft_rst  in  1  synchronous clear, same effect as reset.
REQ-005 i_sub_space_num  in  4  channel field, address bits [26:23].
REQ-006 i_rd_numb  in  12  words per line, valid range 1..128.
REQ-007 i_syn_v  in  1  output-side vertical sync, asynchronous to i_sclk, high for at least 3 i_sclk.
REQ-008 i_wr_frame_numb  in  2  frame currently being written by the write channel.
REQ-009 i_line_req  in  1  single-cycle request for the next line, i_sclk domain.
REQ-010 i_ddr_rd_prio_ini_vld / i_ddr_rd_prio_ini  in  1 / 16  priority initial value load.
REQ-011 o_ddr_rd_priority  out  16  current arbitration priority.
REQ-012 o_ddr_rd_req  out  1  read request to the DDR arbiter; i_ddr_rd_ack  in  1  grant pulse.
REQ-013 o_ddr_rd_start_addr  out  ADDR_WIDTH  {channel[3:0], frame[1:0], row[10:0], col[9:0]=0}.
REQ-014 o_ddr_rd_data_length  out  12  burst length in words.
REQ-015 i_ddr_rd_data_vld / i_ddr_rd_data  in  1 / DATA_WIDTH  returned read beats; i_ddr_rd_done  in  1  burst-complete pulse.
REQ-016 o_ram_wr_en / o_ram_wr_addr / o_ram_wr_data  out  1 / 8 / DATA_WIDTH  line-RAM write port.
REQ-017 o_line_rdy / o_line_half  out  1 / 1  one-cycle pulse: line complete in indicated RAM half.
REQ-018 o_frame_numb  out  2  frame being read; o_ddr_req_lose  out  1  pulse, line request dropped.

Function
REQ-019 SHALL synchronize i_syn_v with two flops and detect its rising edge (vs_rise) on the synchronized signal.
REQ-020 On vs_rise: row<=0, half<=0, o_frame_numb<=i_wr_frame_numb-1 modulo 4 (0 maps to 3).
REQ-021 FSM states: IDLE, REQ, WAIT_DATA, DONE; reset state IDLE.
REQ-022 IDLE->REQ on i_line_req when i_rd_numb is in range 1..128; i_rd_numb latched into o_ddr_rd_data_length, values above 128 clamped to 128.
REQ-023 i_line_req with i_rd_numb=0 SHALL be ignored with no request and no lose pulse.
REQ-024 In REQ, o_ddr_rd_req=1 and address/length are held stable; on i_ddr_rd_ack: req deasserts next cycle, state->WAIT_DATA.
REQ-025 In WAIT_DATA, each i_ddr_rd_data_vld beat writes o_ram_wr_addr={half, beat_cnt[6:0]} with registered data, 1-cycle latency; beat_cnt starts at 0.
REQ-026 Beats beyond the latched length SHALL NOT be written.
REQ-027 On i_ddr_rd_done in WAIT_DATA: state->DONE; a beat coincident with done is still written.
REQ-028 DONE lasts one cycle: o_line_rdy=1, o_line_half=half; then half toggles, row increments (2047 wraps to 0), state->IDLE.
REQ-029 i_line_req outside IDLE SHALL pulse o_ddr_req_lose for one cycle; the request is discarded.
REQ-030 vs_rise outside IDLE SHALL let the current burst complete; the row/half/frame update takes effect for the next request. The DONE increment SHALL NOT overwrite row=0 set by a vs_rise pending during that burst.
REQ-031 Priority: on i_ddr_rd_prio_ini_vld load prio_ini; while in REQ without ack, increment by 1 per cycle, saturating at 16'hFFFF; on ack reload the last loaded ini value; the load has precedence over the increment.

Reset
REQ-032 On i_rst_n low or i_soft_rst high: FSM IDLE, row 0, half 0, beat_cnt 0, all outputs 0, o_ddr_rd_priority 0, stored ini value 0, sync flops 0.
REQ-033 Reset mid-burst SHALL abandon the burst; subsequent data beats are ignored until the next granted request.

Verification
REQ-034 i_sub_space_num=5, i_wr_frame_numb=2, vs pulse, then i_line_req with i_rd_numb=64 -> o_ddr_rd_start_addr={4'h5,2'd1,11'd0,10'd0}, length 64.
REQ-035 Grant, then 64 beats and done -> RAM addresses 0x00..0x3F written; o_line_rdy with half=0; next line writes 0x80..0xBF, row=1.
REQ-036 i_wr_frame_numb=0 at vs -> o_frame_numb=3; i_rd_numb=200 -> length 128; i_rd_numb=0 -> no request.
REQ-037 prio_ini=16'h0010, ack withheld 5 cycles -> priority 0x0015, returns to 0x0010 after ack.
REQ-038 i_line_req during WAIT_DATA -> o_ddr_req_lose single pulse, no second request; i_soft_rst mid-burst -> IDLE and all outputs 0.
